// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and latency constants for divider_32by16.
package div_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_LAT = DIV_WIDTH + 2;
  localparam int DIV_OVF_LAT = 2;
  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on an unsigned partial remainder.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dv,
  output logic [WIDTH-1:0] o_p,
  output logic             o_q
);
  logic [WIDTH:0] w_sh;
  assign w_sh = {i_p, i_bit};
  assign o_q = w_sh >= {1'b0, i_dv};
  assign o_p = o_q ? WIDTH'(w_sh - {1'b0, i_dv}) : w_sh[WIDTH-1:0];
endmodule

// File: rtl/divider_32by16.sv
// divider_32by16: sequential restoring divider, 2W/W bits, St/Done handshake.
// DIV_SIGNED_EN selects signed two's-complement operands; otherwise operands are unsigned.
module divider_32by16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               St,
  input  logic [2*WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0]   Divisor,
  output logic               Done,
  output logic [WIDTH-1:0]   Quotient,
  output logic [WIDTH-1:0]   Remainder,
  output logic               Ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t             r_state;
  logic [2*WIDTH-1:0] r_dd;
  logic [WIDTH-1:0]   r_dv, r_q, r_p;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_mag_dd;
  logic [WIDTH-1:0]   w_mag_dv, w_fix_q, w_fix_r, w_p;
  logic               w_fix_ovf, w_bad, w_qb;
`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] w_qlim;
  assign w_mag_dd = Dividend[2*WIDTH-1] ? -Dividend : Dividend;
  assign w_mag_dv = Divisor[WIDTH-1] ? -Divisor : Divisor;
  // Negative results may reach 2^(W-1) in magnitude, positive ones one less.
  assign w_qlim = QMIN - WIDTH'(!r_neg_q);
  assign w_fix_ovf = r_q > w_qlim;
  assign w_fix_q = w_fix_ovf ? '0 : (r_neg_q ? -r_q : r_q);
  assign w_fix_r = w_fix_ovf ? '0 : (r_neg_r ? -r_p : r_p);
`else
  assign w_mag_dd = Dividend;
  assign w_mag_dv = Divisor;
  assign w_fix_ovf = 1'b0;
  assign w_fix_q = r_q;
  assign w_fix_r = r_p;
`endif
  assign w_bad = (r_dv == '0) || (r_dd[2*WIDTH-1:WIDTH] >= r_dv);
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p  (r_p),
    .i_bit(r_dd[WIDTH-1]),
    .i_dv (r_dv),
    .o_p  (w_p),
    .o_q  (w_qb)
  );
  // Early overflow still passes through FIX so it lands in DONE two edges after capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_dd <= '0;
      r_dv <= '0;
      r_q <= '0;
      r_p <= '0;
      r_cnt <= '0;
      Done <= 1'b0;
      Quotient <= '0;
      Remainder <= '0;
      Ovf <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (St) begin
          r_dd <= w_mag_dd;
          r_dv <= w_mag_dv;
          r_q <= '0;
          r_cnt <= '0;
          Quotient <= '0;
          Remainder <= '0;
          Ovf <= 1'b0;
`ifdef DIV_SIGNED_EN
          r_neg_q <= Dividend[2*WIDTH-1] ^ Divisor[WIDTH-1];
          r_neg_r <= Dividend[2*WIDTH-1];
`endif
          r_state <= CHECK;
        end
        CHECK: begin
          r_p <= r_dd[2*WIDTH-1:WIDTH];
          Ovf <= w_bad;
          r_state <= w_bad ? FIX : DIVIDE;
        end
        DIVIDE: begin
          r_p <= w_p;
          r_q <= {r_q[WIDTH-2:0], w_qb};
          r_dd <= {r_dd[2*WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (!Ovf) begin
            Quotient <= w_fix_q;
            Remainder <= w_fix_r;
            Ovf <= w_fix_ovf;
          end
          Done <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (!St) begin
          Done <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_32by16.sv
// tb_divider_32by16: directed self-checking bench for divider_32by16 in either DIV_SIGNED_EN build.
module tb_divider_32by16;
  import div_pkg::*;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        RST, St;
  logic [31:0] Dividend;
  logic [15:0] Divisor;
  logic        Done, Ovf;
  logic [15:0] Quotient, Remainder;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;

  divider_32by16 dut (
    .CLK(CLK), .RST(RST), .St(St), .Dividend(Dividend), .Divisor(Divisor),
    .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                     input int elat, input logic [15:0] eq, input logic [15:0] er, input logic eovf);
    int lat = 0;
    @(negedge CLK);
    Dividend = dd;
    Divisor = dv;
    St = 1'b1;
    @(posedge CLK);
    #1;
    Dividend = ~dd;
    Divisor = dv ^ 16'h0005;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge CLK);
      #1;
      if (Done) lat = i;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_ovf"}, Ovf, eovf);
  endtask

  task automatic drop(input string tag);
    @(negedge CLK);
    St = 1'b0;
    @(posedge CLK);
    #1;
    chk({tag, "_drop"}, Done, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    St = 1'b0;
    Dividend = '0;
    Divisor = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_done", Done, 1'b0);
    chk("rst_q", Quotient, 16'h0);
    chk("rst_r", Remainder, 16'h0);
    chk("rst_ovf", Ovf, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    run("pos", 32'd100, 16'd7, DIV_LAT, 16'd14, 16'd2, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("hold_done", Done, 1'b1);
    chk("hold_q", Quotient, 16'd14);
    drop("pos");
    chk("after_drop_q", Quotient, 16'd14);
    run("neg_dd", 32'hFFFFFF9C, 16'd7, SGN ? DIV_LAT : DIV_OVF_LAT,
        SGN ? 16'hFFF2 : 16'h0, SGN ? 16'hFFFE : 16'h0, !SGN);
    drop("neg_dd");
    run("neg_dv", 32'd100, 16'hFFF9, DIV_LAT, SGN ? 16'hFFF2 : 16'h0, SGN ? 16'd2 : 16'd100, 1'b0);
    drop("neg_dv");
    run("both_neg", 32'hFFFFFC18, 16'hFFFD, SGN ? DIV_LAT : DIV_OVF_LAT,
        SGN ? 16'd333 : 16'h0, SGN ? 16'hFFFF : 16'h0, !SGN);
    drop("both_neg");
    run("dz", 32'h00001234, 16'd0, DIV_OVF_LAT, 16'h0, 16'h0, 1'b1);
    drop("dz");
    run("hi_ovf", 32'h00010000, 16'd1, DIV_OVF_LAT, 16'h0, 16'h0, 1'b1);
    drop("hi_ovf");
    run("pos_rng", 32'h00008000, 16'd1, DIV_LAT, SGN ? 16'h0 : 16'h8000, 16'h0, SGN);
    drop("pos_rng");
    run("neg_min", 32'hFFFF8000, 16'd1, SGN ? DIV_LAT : DIV_OVF_LAT,
        SGN ? 16'h8000 : 16'h0, 16'h0, !SGN);
    drop("neg_min");
    run("ffff", 32'h0000FFFF, 16'hFFFF, DIV_LAT, SGN ? 16'h0 : 16'd1, 16'h0, SGN);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_done", Done, 1'b0);
    chk("arst_q", Quotient, 16'h0);
    chk("arst_ovf", Ovf, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    St = 1'b0;
    @(negedge CLK);
    Dividend = 32'd1000;
    Divisor = 16'd3;
    St = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    St = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_done", Done, 1'b0);
    chk("mid_rst_q", Quotient, 16'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("mid_rst_idle", Done, 1'b0);
    run("after_rst", 32'd1000, 16'd3, DIV_LAT, 16'd333, 16'd1, 1'b0);
    drop("after_rst");
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
